// File: rtl/uart_autobaud_pkg.sv
// Shared definitions for the UART auto-baud controller: FSM state encoding,
// error codes and calibration constants.
package uart_autobaud_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    MEASURE = 3'd2,
    CALC    = 3'd3,
    APPLY   = 3'd4,
    ERROR   = 3'd5
  } ab_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_FAST    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Falling edges in a 0x55 sync character: start bit plus bits 1, 3, 5, 7.
  localparam int          SYNC_EDGES   = 5;
  localparam logic [12:0] BAUD_VAL_MAX = 13'h1FFF;

endpackage

// File: rtl/uart_rx_edge_sync.sv
// Brings the asynchronous RX line into the clk_i domain and flags falling
// edges. All flops reset to 1 (idle line) so reset release never looks like
// a start bit.
//   clk_i    system clock
//   reset_i  asynchronous active-high reset
//   rx_i     raw serial input
//   fe_o     high for one cycle per synchronized 1->0 transition
module uart_rx_edge_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic rx_i,
  output logic fe_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fe_o = prev_q & ~sync2_q;

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud calibration: measures eight bit-times of a received 0x55 and
// programs the 16x baud generator (baud_val + 3-bit fraction).
//   clk_i                system clock
//   reset_i              asynchronous active-high reset
//   start_i / abort_i    one-cycle control pulses from the register block
//   rx_i                 raw serial input
//   baud_val_o           13-bit generator divisor
//   baud_val_fraction_o  3-bit generator fraction
//   rx_hold_o            receiver should ignore the line
//   busy_o               controller not idle
//   done_o / err_o       one-cycle completion / failure pulses
//   err_code_o           last failure cause, cleared by an accepted start
//
// state   | meaning
// IDLE    | outputs held, waiting for start
// ARMED   | waiting for the start-bit falling edge (no timeout)
// MEASURE | counting clocks until the 5th falling edge
// CALC    | derive divisor and fraction from the measured span
// APPLY   | new values on the outputs, done pulse
// ERROR   | err pulse, outputs unchanged
module uart_autobaud_ctrl
  import uart_autobaud_pkg::*;
#(
  parameter logic [12:0] DEFAULT_BAUD_VAL = 13'd1,
  parameter logic [2:0]  DEFAULT_FRACTION = 3'd0,
  parameter int          CNT_W            = 21
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        rx_i,
  output logic [12:0] baud_val_o,
  output logic [2:0]  baud_val_fraction_o,
  output logic        rx_hold_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  localparam int QW = CNT_W + 1;

  ab_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       edge_cnt_q, edge_cnt_d;
  logic [QW-1:0]    m_q, m_d;
  logic [12:0]      baud_val_q, baud_val_d;
  logic [2:0]       frac_q, frac_d;
  logic [1:0]       err_code_q, err_code_d;

  logic          fe;
  logic          last_edge;
  logic [QW-1:0] q_w;
  logic [QW-1:0] bv_full_w;
  logic          too_fast_w;
  logic          clamp_w;

  uart_rx_edge_sync u_edge_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .rx_i    (rx_i),
    .fe_o    (fe)
  );

  // T = 16*(bv+1) + 2*frac and M = 8T, so M/16 = 8*(bv+1) + frac.
  // Adding 8 before the shift rounds to nearest.
  assign q_w        = (m_q + QW'(8)) >> 4;
  assign bv_full_w  = (q_w >> 3) - QW'(1);
  assign too_fast_w = (q_w < QW'(8));
  assign clamp_w    = (bv_full_w > QW'(BAUD_VAL_MAX));

  assign last_edge  = fe && (edge_cnt_q == 3'(SYNC_EDGES - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_cnt_d = edge_cnt_q;
    m_d        = m_q;
    baud_val_d = baud_val_q;
    frac_d     = frac_q;
    err_code_d = err_code_q;

    if (abort_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d    = ARMED;
            err_code_d = ERR_NONE;
          end
        end
        ARMED: begin
          if (fe) begin
            state_d    = MEASURE;
            cnt_d      = '0;
            edge_cnt_d = 3'd1;
          end
        end
        MEASURE: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (fe) edge_cnt_d = edge_cnt_q + 3'd1;
          // cnt_q lags the edge-1 detect cycle by one, hence the +1.
          if (last_edge) begin
            state_d = CALC;
            m_d     = {1'b0, cnt_q} + QW'(1);
          end else if (cnt_q == '1) begin
            state_d    = ERROR;
            err_code_d = ERR_TIMEOUT;
          end
        end
        CALC: begin
          if (too_fast_w) begin
            state_d    = ERROR;
            err_code_d = ERR_FAST;
          end else begin
            state_d = APPLY;
            if (clamp_w) begin
              baud_val_d = BAUD_VAL_MAX;
              frac_d     = 3'd7;
            end else begin
              baud_val_d = bv_full_w[12:0];
              frac_d     = q_w[2:0];
            end
          end
        end
        APPLY:   state_d = IDLE;
        ERROR:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      edge_cnt_q <= '0;
      m_q        <= '0;
      baud_val_q <= DEFAULT_BAUD_VAL;
      frac_q     <= DEFAULT_FRACTION;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_cnt_q <= edge_cnt_d;
      m_q        <= m_d;
      baud_val_q <= baud_val_d;
      frac_q     <= frac_d;
      err_code_q <= err_code_d;
    end
  end

  assign baud_val_o          = baud_val_q;
  assign baud_val_fraction_o = frac_q;
  assign err_code_o          = err_code_q;
  assign busy_o              = (state_q != IDLE);
  assign rx_hold_o           = (state_q == ARMED) || (state_q == MEASURE) || (state_q == CALC);
  // An abort landing on the pulse cycle suppresses the pulse.
  assign done_o              = (state_q == APPLY) && !abort_i;
  assign err_o               = (state_q == ERROR) && !abort_i;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
module tb_uart_autobaud_ctrl;

  logic clk = 1'b0;
  logic reset, start, start_t, abort, rx;

  logic [12:0] baud_val, baud_val_t;
  logic [2:0]  frac, frac_t;
  logic        rx_hold, busy, done, err;
  logic        rx_hold_t, busy_t, done_t, err_t;
  logic [1:0]  err_code, err_code_t;

  int cmp_cnt = 0;
  int mis_cnt = 0;

  always #10 clk = ~clk;

  uart_autobaud_ctrl dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort), .rx_i(rx),
    .baud_val_o(baud_val), .baud_val_fraction_o(frac), .rx_hold_o(rx_hold),
    .busy_o(busy), .done_o(done), .err_o(err), .err_code_o(err_code)
  );

  uart_autobaud_ctrl #(.CNT_W(12)) dut_t (
    .clk_i(clk), .reset_i(reset), .start_i(start_t), .abort_i(abort), .rx_i(rx),
    .baud_val_o(baud_val_t), .baud_val_fraction_o(frac_t), .rx_hold_o(rx_hold_t),
    .busy_o(busy_t), .done_o(done_t), .err_o(err_t), .err_code_o(err_code_t)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // n falling edges spaced gap cycles apart; returns right after the last
  // edge is driven (line left low).
  task automatic send_edges(input int gap, input int n);
    for (int i = 0; i < n; i++) begin
      rx = 1'b0;
      if (i < n - 1) begin
        repeat (gap / 2) cyc();
        rx = 1'b1;
        repeat (gap - gap / 2) cyc();
      end
    end
  endtask

  // Called right after the 5th edge is driven. Edge reaches fe-detect at
  // sample 2, CALC at 3, APPLY (done + new outputs) at 4.
  task automatic wait_done(input string name, input logic [12:0] exp_bv, input logic [2:0] exp_fr);
    int got = 0;
    for (int k = 1; k <= 40 && got == 0; k++) begin
      cyc();
      if (k == 2) rx = 1'b1;
      if (done === 1'b1) got = k;
      else if (err === 1'b1) got = -k;
    end
    cmp_cnt++;
    if (got !== 4) begin
      $display("FAIL %s done_latency: got sample %0d, want 4", name, got); mis_cnt++;
    end
    cmp_cnt++;
    if (baud_val !== exp_bv || frac !== exp_fr) begin
      $display("FAIL %s values: got %0d/%0d, want %0d/%0d", name, baud_val, frac, exp_bv, exp_fr); mis_cnt++;
    end
    cmp_cnt++;
    if (err_code !== 2'b00 || rx_hold !== 1'b0) begin
      $display("FAIL %s apply_flags: err_code %b rx_hold %b, want 00/0", name, err_code, rx_hold); mis_cnt++;
    end
    cyc();
    cmp_cnt++;
    if (done !== 1'b0 || busy !== 1'b0 || baud_val !== exp_bv || frac !== exp_fr) begin
      $display("FAIL %s after_apply: done %b busy %b bv %0d fr %0d", name, done, busy, baud_val, frac); mis_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; start_t = 0; abort = 0; rx = 1'b1;
    repeat (3) cyc();
    cmp_cnt++;
    if (baud_val !== 13'd1 || frac !== 3'd0 || rx_hold !== 0 || busy !== 0 ||
        done !== 0 || err !== 0 || err_code !== 2'b00) begin
      $display("FAIL reset_values: bv %0d fr %0d hold %b busy %b done %b err %b code %b",
               baud_val, frac, rx_hold, busy, done, err, err_code); mis_cnt++;
    end
    reset = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic test_too_fast();
    int got = 0;
    pulse_start();
    cmp_cnt++;
    if (busy !== 1'b1 || rx_hold !== 1'b1) begin
      $display("FAIL fast_armed: busy %b rx_hold %b, want 1/1", busy, rx_hold); mis_cnt++;
    end
    send_edges(25, 5);  // M=100, Q=6
    for (int k = 1; k <= 40 && got == 0; k++) begin
      cyc();
      if (k == 2) rx = 1'b1;
      if (err === 1'b1) got = k;
      else if (done === 1'b1) got = -k;
    end
    cmp_cnt++;
    if (got !== 4) begin
      $display("FAIL fast_err_latency: got sample %0d, want 4", got); mis_cnt++;
    end
    cmp_cnt++;
    if (err_code !== 2'b01 || baud_val !== 13'd1 || frac !== 3'd0 || rx_hold !== 1'b0) begin
      $display("FAIL fast_err_state: code %b bv %0d fr %0d hold %b, want 01/1/0/0",
               err_code, baud_val, frac, rx_hold); mis_cnt++;
    end
    repeat (5) cyc();
    cmp_cnt++;
    if (err_code !== 2'b01 || busy !== 1'b0 || err !== 1'b0) begin
      $display("FAIL fast_code_held: code %b busy %b err %b, want 01/0/0", err_code, busy, err); mis_cnt++;
    end
  endtask

  task automatic test_timeout();
    int got = 0;
    logic hold_before = 1'b0;
    start_t = 1'b1; cyc(); start_t = 1'b0;
    send_edges(20, 3);  // now 40 samples after edge 1 drive
    for (int k = 41; k <= 4300 && got == 0; k++) begin
      cyc();
      if (k == 42) rx = 1'b1;
      if (err_t === 1'b1) got = k;
      else hold_before = rx_hold_t;
    end
    // edge-1 detect at sample 2, cnt=0 at 3, cnt=4095 at 4098, ERROR at 4099
    cmp_cnt++;
    if (got !== 4099) begin
      $display("FAIL timeout_latency: got sample %0d, want 4099", got); mis_cnt++;
    end
    cmp_cnt++;
    if (err_code_t !== 2'b10 || rx_hold_t !== 1'b0 || hold_before !== 1'b1 ||
        baud_val_t !== 13'd1 || frac_t !== 3'd0 || done_t !== 1'b0) begin
      $display("FAIL timeout_state: code %b hold %b prev_hold %b bv %0d fr %0d done %b",
               err_code_t, rx_hold_t, hold_before, baud_val_t, frac_t, done_t); mis_cnt++;
    end
    cyc();
    cmp_cnt++;
    if (busy_t !== 1'b0 || err_code_t !== 2'b10 || err_t !== 1'b0) begin
      $display("FAIL timeout_idle: busy %b code %b err %b", busy_t, err_code_t, err_t); mis_cnt++;
    end
  endtask

  task automatic test_115200();
    pulse_start();
    cmp_cnt++;
    if (err_code !== 2'b00) begin
      $display("FAIL start_clears_code: got %b, want 00", err_code); mis_cnt++;
    end
    send_edges(868, 5);  // T=434, M=3472, Q=217
    wait_done("b115200", 13'd26, 3'd1);
  endtask

  task automatic test_t64();
    pulse_start();
    send_edges(128, 5);  // M=512, Q=32
    wait_done("t64", 13'd3, 3'd0);
    cmp_cnt++;
    if (16 * (int'(baud_val) + 1) + 2 * int'(frac) !== 64) begin
      $display("FAIL t64_bit_time: got %0d, want 64", 16 * (int'(baud_val) + 1) + 2 * int'(frac)); mis_cnt++;
    end
  endtask

  task automatic test_restart_ignored();
    pulse_start();
    send_edges(200, 3);
    repeat (100) cyc();
    rx = 1'b1;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cmp_cnt++;
    if (busy !== 1'b1 || rx_hold !== 1'b1) begin
      $display("FAIL restart_busy: busy %b hold %b, want 1/1", busy, rx_hold); mis_cnt++;
    end
    repeat (98) cyc();
    send_edges(200, 2);  // M=800, Q=50
    wait_done("restart", 13'd5, 3'd2);
  endtask

  task automatic test_abort();
    int seen = 0;
    pulse_start();
    send_edges(50, 3);
    repeat (5) cyc();
    rx = 1'b1;
    repeat (5) cyc();
    abort = 1'b1;
    cyc();
    cmp_cnt++;
    if (busy !== 1'b0 || rx_hold !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        baud_val !== 13'd5 || frac !== 3'd2) begin
      $display("FAIL abort_idle: busy %b hold %b done %b err %b bv %0d fr %0d",
               busy, rx_hold, done, err, baud_val, frac); mis_cnt++;
    end
    abort = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (done === 1'b1 || err === 1'b1 || busy === 1'b1) seen++;
    end
    cmp_cnt++;
    if (seen !== 0) begin
      $display("FAIL abort_quiet: got %0d active cycles, want 0", seen); mis_cnt++;
    end
    start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    cmp_cnt++;
    if (busy !== 1'b0) begin
      $display("FAIL start_abort_idle: busy %b, want 0", busy); mis_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send_edges(50, 3);
    repeat (10) cyc();
    rx = 1'b1;
    cmp_cnt++;
    if (busy !== 1'b1 || baud_val !== 13'd5) begin
      $display("FAIL pre_reset: busy %b bv %0d, want 1/5", busy, baud_val); mis_cnt++;
    end
    reset = 1'b1;
    #1;
    cmp_cnt++;
    if (baud_val !== 13'd1 || frac !== 3'd0 || busy !== 0 || rx_hold !== 0 ||
        done !== 0 || err !== 0 || err_code !== 2'b00 || err_code_t !== 2'b00) begin
      $display("FAIL reset_mid: bv %0d fr %0d busy %b hold %b done %b err %b code %b code_t %b",
               baud_val, frac, busy, rx_hold, done, err, err_code, err_code_t); mis_cnt++;
    end
    cyc();
    reset = 1'b0;
    repeat (2) cyc();
  endtask

  initial begin
    test_reset();
    test_too_fast();
    test_timeout();
    test_115200();
    test_t64();
    test_restart_ignored();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
